// File: rtl/seg_disp_ctrl.sv
// Seven-segment view sequencer: mirrors mode/op/matrix to the display
// driver, or shows a timed error countdown that ticks once per second.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   sys_mode[1:0]     top-level mode (00 MENU .. 11 OPERATION)
//   op_sel_in[2:0]    selected operation code
//   matrix_id_in[3:0] current matrix number
//   err_start         pulse: load countdown from err_time (clamped)
//   err_time[7:0]     requested countdown seconds
//   err_clear         pulse: abort error view (no err_done)
//   mode_sel[1:0]     to driver; forced to 00 while in error view
//   op_sel[2:0]       to driver
//   countdown_val[7:0] to driver; seconds remaining
//   matrix_id_out[3:0] to driver
//   err_active        high while in error view
//   err_done          one-cycle pulse on natural expiry
module seg_disp_ctrl #(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned MIN_T       = 5,
  parameter int unsigned MAX_T       = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sys_mode,
  input  logic [2:0] op_sel_in,
  input  logic [3:0] matrix_id_in,
  input  logic       err_start,
  input  logic [7:0] err_time,
  input  logic       err_clear,
  output logic [1:0] mode_sel,
  output logic [2:0] op_sel,
  output logic [7:0] countdown_val,
  output logic [3:0] matrix_id_out,
  output logic       err_active,
  output logic       err_done
);

  localparam int unsigned PW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);
  localparam logic [7:0] MINV = 8'(MIN_T);
  localparam logic [7:0] MAXV = 8'(MAX_T);

  typedef enum logic {
    NORMAL,
    ERR
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    mid_q, mid_d;
  logic          done_q, done_d;
  logic [7:0]    load_v;

  always_comb begin
    load_v = err_time;
    if (err_time < MINV) begin
      load_v = MINV;
    end else if (err_time > MAXV) begin
      load_v = MAXV;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    mode_d  = sys_mode;
    op_d    = op_sel_in;
    mid_d   = matrix_id_in;
    done_d  = 1'b0;
    // A new start always wins over clear and over an expiry tick.
    if (err_start) begin
      state_d = ERR;
      presc_d = '0;
      cnt_d   = load_v;
      mode_d  = 2'b00;
    end else begin
      unique case (state_q)
        NORMAL: begin
          presc_d = '0;
          cnt_d   = '0;
        end
        ERR: begin
          if (err_clear) begin
            state_d = NORMAL;
            presc_d = '0;
            cnt_d   = '0;
          end else if (presc_q == PMAX) begin
            presc_d = '0;
            if (cnt_q <= 8'd1) begin
              state_d = NORMAL;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d  = cnt_q - 8'd1;
              mode_d = 2'b00;
            end
          end else begin
            presc_d = presc_q + 1'b1;
            mode_d  = 2'b00;
          end
        end
        default: begin
          state_d = NORMAL;
          presc_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      presc_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      op_q    <= '0;
      mid_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      mid_q   <= mid_d;
      done_q  <= done_d;
    end
  end

  assign mode_sel      = mode_q;
  assign op_sel        = op_q;
  assign countdown_val = cnt_q;
  assign matrix_id_out = mid_q;
  assign err_active    = (state_q == ERR);
  assign err_done      = done_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Bench for seg_disp_ctrl with a 10-cycle second.
// Expected outputs are queued as stimulus is driven.
module tb_seg_disp_ctrl;

  localparam int TICK = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sys_mode;
  logic [2:0] op_sel_in;
  logic [3:0] matrix_id_in;
  logic       err_start;
  logic [7:0] err_time;
  logic       err_clear;
  logic [1:0] mode_sel;
  logic [2:0] op_sel;
  logic [7:0] countdown_val;
  logic [3:0] matrix_id_out;
  logic       err_active;
  logic       err_done;

  seg_disp_ctrl #(
    .TICK_CYCLES(TICK),
    .MIN_T(5),
    .MAX_T(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sys_mode(sys_mode),
    .op_sel_in(op_sel_in),
    .matrix_id_in(matrix_id_in),
    .err_start(err_start),
    .err_time(err_time),
    .err_clear(err_clear),
    .mode_sel(mode_sel),
    .op_sel(op_sel),
    .countdown_val(countdown_val),
    .matrix_id_out(matrix_id_out),
    .err_active(err_active),
    .err_done(err_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] op;
    logic [7:0] cd;
    logic [3:0] mid;
    logic       act;
    logic       done;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // independent view: load time and cycles elapsed since load
  bit m_err;
  int m_cnt;
  int m_age;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, act, exp, $time);
    end
  endtask

  function automatic int clampt(input int t);
    if (t < 5) return 5;
    if (t > 15) return 15;
    return t;
  endfunction

  task automatic step(input logic [1:0] sm, input logic [2:0] op,
                      input logic [3:0] mid, input logic st,
                      input logic [7:0] tm, input logic clr);
    exp_t e;
    exp_t g;
    bit   dn;
    @(negedge clk);
    sys_mode     = sm;
    op_sel_in    = op;
    matrix_id_in = mid;
    err_start    = st;
    err_time     = tm;
    err_clear    = clr;
    dn = 1'b0;
    if (st) begin
      m_err = 1'b1;
      m_cnt = clampt(int'(tm));
      m_age = 0;
    end else if (m_err && clr) begin
      m_err = 1'b0;
      m_cnt = 0;
    end else if (m_err) begin
      m_age++;
      if (m_age == TICK) begin
        m_age = 0;
        m_cnt--;
        if (m_cnt == 0) begin
          m_err = 1'b0;
          dn = 1'b1;
        end
      end
    end
    e.mode = m_err ? 2'b00 : sm;
    e.op   = op;
    e.mid  = mid;
    e.cd   = m_err ? 8'(m_cnt) : 8'd0;
    e.act  = m_err;
    e.done = dn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("mode_sel", 32'(mode_sel), 32'(g.mode));
    check("op_sel", 32'(op_sel), 32'(g.op));
    check("matrix_id", 32'(matrix_id_out), 32'(g.mid));
    check("countdown", 32'(countdown_val), 32'(g.cd));
    check("err_active", 32'(err_active), 32'(g.act));
    check("err_done", 32'(err_done), 32'(g.done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(2'b01, 3'd3, 4'd2, 1'b0, 8'd0, 1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_mode"}, 32'(mode_sel), 0);
    check({tag, "_op"}, 32'(op_sel), 0);
    check({tag, "_cd"}, 32'(countdown_val), 0);
    check({tag, "_mid"}, 32'(matrix_id_out), 0);
    check({tag, "_act"}, 32'(err_active), 0);
    check({tag, "_done"}, 32'(err_done), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    sys_mode     = 2'b01;
    op_sel_in    = 3'd3;
    matrix_id_in = 4'd2;
    err_start    = 1'b0;
    err_time     = 8'd0;
    err_clear    = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    m_age = 0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // mirror after reset release
    idle(2);
    step(2'b11, 3'd4, 4'd9, 1'b0, 8'd0, 1'b0);

    // countdown from 7 through natural expiry
    step(2'b01, 3'd3, 4'd2, 1'b1, 8'd7, 1'b0);
    idle(75);

    // clamping
    step(2'b10, 3'd1, 4'd5, 1'b1, 8'd2, 1'b0);
    step(2'b10, 3'd1, 4'd5, 1'b1, 8'd40, 1'b0);
    step(2'b10, 3'd1, 4'd5, 1'b1, 8'd15, 1'b0);
    step(2'b10, 3'd1, 4'd5, 1'b1, 8'd200, 1'b0);
    step(2'b10, 3'd1, 4'd5, 1'b1, 8'd0, 1'b0);
    step(2'b10, 3'd1, 4'd5, 1'b1, 8'd9, 1'b0);
    step(2'b10, 3'd1, 4'd5, 1'b0, 8'd0, 1'b1);
    // clear in NORMAL is ignored
    step(2'b10, 3'd1, 4'd5, 1'b0, 8'd0, 1'b1);

    // abort mid-count, then reload
    step(2'b01, 3'd3, 4'd2, 1'b1, 8'd10, 1'b0);
    idle(25);
    step(2'b01, 3'd3, 4'd2, 1'b0, 8'd0, 1'b1);
    idle(10);
    step(2'b01, 3'd3, 4'd2, 1'b1, 8'd6, 1'b0);
    idle(15);

    // start and clear together: start wins
    step(2'b11, 3'd2, 4'd7, 1'b1, 8'd4, 1'b0);
    idle(5);
    step(2'b11, 3'd2, 4'd7, 1'b1, 8'd12, 1'b1);
    idle(12);
    step(2'b01, 3'd3, 4'd2, 1'b0, 8'd0, 1'b1);

    // start on the expiry tick: reload, no done
    step(2'b01, 3'd3, 4'd2, 1'b1, 8'd5, 1'b0);
    idle(49);
    step(2'b01, 3'd3, 4'd2, 1'b1, 8'd9, 1'b0);
    idle(5);

    // async reset mid-countdown at 3
    step(2'b01, 3'd3, 4'd2, 1'b1, 8'd0, 1'b0);
    idle(25);
    check("pre_rst_cd", 32'(countdown_val), 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    m_err = 1'b0;
    m_cnt = 0;
    m_age = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Sequences what the 4-digit seven-segment display shows.
- Arbitrates between the normal mode/operation view and a timed error view that counts down once per second.
- Owns the error countdown engine and drives the display driver's mode_sel, op_sel, countdown_val and matrix_id_out inputs.
- Sits between the top-level menu FSM and the seven-segment scan driver.

Parameters:
- TICK_CYCLES, 100_000_000: clock cycles per countdown second (100 MHz system clock).
- MIN_T, 5: minimum error countdown, seconds.
- MAX_T, 15: maximum error countdown, seconds.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sys_mode  in  2  top-level mode: 00 MENU, 01 INPUT, 10 GEN, 11 OPERATION
- op_sel_in  in  3  selected operation code (0 T, 1 A, 2 b, 3 C, 4 J)
- matrix_id_in  in  4  current matrix number
- err_start  in  1  one-cycle pulse: enter error view
- err_time  in  8  requested countdown seconds, sampled with err_start
- err_clear  in  1  one-cycle pulse: abort error view
- mode_sel  out  2  to display driver
- op_sel  out  3  to display driver
- countdown_val  out  8  to display driver, seconds remaining
- matrix_id_out  out  4  to display driver
- err_active  out  1  high while in the ERR state
- err_done  out  1  one-cycle pulse when the countdown expires naturally

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low.
- Reset values: mode_sel=00, op_sel=0, countdown_val=0, matrix_id_out=0, err_active=0, err_done=0, state NORMAL, prescaler=0.
- All outputs are registered.

States:
- NORMAL:
  - Mirrors inputs with 1-cycle latency: mode_sel<=sys_mode, op_sel<=op_sel_in, matrix_id_out<=matrix_id_in.
  - countdown_val held at 0.
  - err_active=0.
- ERR:
  - mode_sel forced to 00; countdown_val = seconds remaining.
  - op_sel and matrix_id_out keep tracking their inputs.
  - err_active=1.

Load rule:
- On err_start, countdown is loaded with err_time clamped to [MIN_T, MAX_T]. Examples: err_time=0 gives 5; 200 gives 15; 9 gives 9.
- The prescaler clears to 0 on the same edge.
- State becomes ERR; err_active and countdown_val are valid on the cycle after err_start.

Prescaler and countdown:
- In ERR the prescaler counts 0..TICK_CYCLES-1 and wraps.
- On wrap (tick), countdown_val decrements by 1.
- On the tick where countdown_val==1:
  - countdown_val<=0, state<=NORMAL, err_active<=0, err_done<=1 for exactly one cycle.
  - Outputs resume mirroring inputs on that same edge.
- The first decrement occurs exactly TICK_CYCLES cycles after the load edge.

Event rules:
- err_start while in ERR: reload with the new clamped value, prescaler restarts, no err_done.
- err_clear in ERR:
  - Next edge: NORMAL, countdown_val=0, prescaler=0, err_active=0.
  - err_done is NOT pulsed.
- err_clear in NORMAL: ignored.
- err_start and err_clear in the same cycle: err_start wins (load); err_clear is ignored.
- err_start on the same cycle as an expiry tick: reload wins; err_done is not pulsed.
- The prescaler is idle (held at 0) in NORMAL.
- countdown_val never underflows and never exceeds MAX_T.
- Reset asserted mid-countdown: immediate return to reset values; no err_done.

Test Plan:
1. Reset release, TICK_CYCLES=10, sys_mode=01, op_sel_in=3, matrix_id_in=2 -> one cycle later mode_sel=01, op_sel=3, matrix_id_out=2, countdown_val=0, err_active=0.
2. err_start with err_time=7 -> next cycle mode_sel=00, countdown_val=7, err_active=1. countdown_val goes 6 at +10 cycles, then 1 at +60. At +70: countdown_val=0, err_done high for 1 cycle, mode_sel returns to sys_mode.
3. err_time=2 -> countdown_val=5. err_time=40 -> countdown_val=15. err_time=15 -> countdown_val=15.
4. err_start (err_time=10), wait 25 cycles (countdown_val=8), then err_clear -> next cycle countdown_val=0, err_active=0, no err_done pulse ever. A second err_start with err_time=6 reloads 6, and its first decrement is 10 cycles later.
5. In ERR with countdown_val=4, err_start (err_time=12) and err_clear in the same cycle -> countdown_val=12, err_active stays 1, prescaler restarted.
6. rst_n pulsed low asynchronously mid-countdown (countdown_val=3) -> outputs zero immediately without a clock edge. After release: NORMAL, no err_done.
